// File: rtl/tl_pkg.sv
// Shared TileLink A/C channel types, opcode constants and beat helpers.
// Imported by the merged-stream splitter and its skid FIFO.
package tl_pkg;

    localparam int OPCODE_WTH = 3;
    localparam int PARAM_WTH  = 3;
    localparam int SIZE_WTH   = 4;
    localparam int SRC_WTH    = 8;
    localparam int ADDR_WTH   = 32;
    localparam int DATA_WTH   = 64;
    localparam int MASK_WTH   = DATA_WTH / 8;

    // Largest burst is 2^(2^SIZE_WTH-1) bytes; the beat counter holds that count without wrapping.
    localparam int MAX_BEATS    = (2 ** (2 ** SIZE_WTH - 1)) / MASK_WTH;
    localparam int BEAT_CNT_WTH = $clog2(MAX_BEATS) + 1;

    typedef logic [BEAT_CNT_WTH-1:0] beat_cnt_t;
    typedef logic [OPCODE_WTH-1:0]   opcode_t;

    localparam opcode_t A_PUT_FULL      = 3'd0;
    localparam opcode_t A_PUT_PARTIAL   = 3'd1;
    localparam opcode_t A_ARITH         = 3'd2;
    localparam opcode_t A_LOGICAL       = 3'd3;
    localparam opcode_t A_GET           = 3'd4;
    localparam opcode_t A_HINT          = 3'd5;
    localparam opcode_t A_ACQUIRE_BLOCK = 3'd6;
    localparam opcode_t A_ACQUIRE_PERM  = 3'd7;

    localparam opcode_t C_ACCESS_ACK      = 3'd0;
    localparam opcode_t C_ACCESS_ACK_DATA = 3'd1;
    localparam opcode_t C_HINT_ACK        = 3'd2;
    localparam opcode_t C_PROBE_ACK       = 3'd4;
    localparam opcode_t C_PROBE_ACK_DATA  = 3'd5;
    localparam opcode_t C_RELEASE         = 3'd6;
    localparam opcode_t C_RELEASE_DATA    = 3'd7;

    typedef struct packed {
        opcode_t               opcode;
        logic [PARAM_WTH-1:0]  param;
        logic [SIZE_WTH-1:0]   size;
        logic [SRC_WTH-1:0]    source;
        logic [ADDR_WTH-1:0]   address;
        logic [DATA_WTH-1:0]   data;
        logic [MASK_WTH-1:0]   mask;
        logic                  corrupt;
    } tl_a_t;

    typedef struct packed {
        opcode_t               opcode;
        logic [PARAM_WTH-1:0]  param;
        logic [SIZE_WTH-1:0]   size;
        logic [SRC_WTH-1:0]    source;
        logic [ADDR_WTH-1:0]   address;
        logic [DATA_WTH-1:0]   data;
        logic                  corrupt;
    } tl_c_t;

    // FIFO entry: route bit (1 = C channel) alongside the A-shaped payload.
    typedef struct packed {
        logic  route;
        tl_a_t bits;
    } tl_fifo_ent_t;

    function automatic beat_cnt_t tl_num_beats(input logic [SIZE_WTH-1:0] size,
                                               input int unsigned data_bytes = MASK_WTH);
        int unsigned nbytes;
        nbytes = 32'd1 << size;
        if (nbytes <= data_bytes) return beat_cnt_t'(1);
        return beat_cnt_t'(nbytes / data_bytes);
    endfunction

    function automatic logic tl_a_has_data(input opcode_t op);
        return (op == A_PUT_FULL) || (op == A_PUT_PARTIAL) ||
               (op == A_ARITH)    || (op == A_LOGICAL);
    endfunction

    function automatic logic tl_c_has_data(input opcode_t op);
        return (op == C_ACCESS_ACK_DATA) || (op == C_PROBE_ACK_DATA) ||
               (op == C_RELEASE_DATA);
    endfunction

endpackage

// File: rtl/tl_skid_fifo.sv
// Two-entry register FIFO; ready depends only on the registered count so the
// upstream accept never sees a combinational path from the downstream ready.
module tl_skid_fifo #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    output logic             ready_o,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] dout_o
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             do_push;
    logic             do_pop;

    assign ready_o = (count != 2'd2);
    assign valid_o = (count != 2'd0);
    assign dout_o  = mem[rd_ptr];
    assign do_push = push_i & ready_o;
    assign do_pop  = pop_i & valid_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset; it is only observed behind valid_o.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= din_i;
        end
    end

endmodule

// File: rtl/tl_a_split_c.sv
// Splits a merged A-shaped stream back onto A and C channels using a sideband
// origin bit, holding multi-beat data bursts on the channel of their first beat.
module tl_a_split_c
    import tl_pkg::*;
#(
    parameter int          DEPTH      = 2,
    parameter int unsigned DATA_BYTES = tl_pkg::MASK_WTH
) (
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  in_valid_i,
    output logic  in_ready_o,
    input  logic  in_is_c_i,
    input  tl_a_t in_bits_i,
    output logic  a_valid_o,
    input  logic  a_ready_i,
    output tl_a_t a_bits_o,
    output logic  c_valid_o,
    input  logic  c_ready_i,
    output tl_c_t c_bits_o,
    output logic  err_o
);

    logic         lock_route_q;
    beat_cnt_t    remaining_q;
    logic         err_q;

    logic         push;
    logic         locked;
    logic         has_data;
    beat_cnt_t    beats;
    tl_fifo_ent_t push_ent;
    tl_fifo_ent_t head_ent;
    logic         head_valid;
    logic         pop;

    always_comb begin
        locked   = (remaining_q != '0);
        beats    = tl_num_beats(in_bits_i.size, DATA_BYTES);
        has_data = in_is_c_i ? tl_c_has_data(in_bits_i.opcode)
                             : tl_a_has_data(in_bits_i.opcode);
        push     = in_valid_i & in_ready_o;
        push_ent.bits  = in_bits_i;
        // A mismatching beat mid-burst is flagged but still follows the locked route.
        push_ent.route = locked ? lock_route_q : in_is_c_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_route_q <= 1'b0;
            remaining_q  <= '0;
            err_q        <= 1'b0;
        end else if (push) begin
            if (locked) begin
                remaining_q <= remaining_q - beat_cnt_t'(1);
                if (in_is_c_i != lock_route_q) begin
                    err_q <= 1'b1;
                end
            end else if (has_data && (beats > beat_cnt_t'(1))) begin
                lock_route_q <= in_is_c_i;
                remaining_q  <= beats - beat_cnt_t'(1);
            end
        end
    end

    tl_skid_fifo #(
        .WIDTH ($bits(tl_fifo_ent_t))
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (in_valid_i),
        .din_i   (push_ent),
        .ready_o (in_ready_o),
        .pop_i   (pop),
        .valid_o (head_valid),
        .dout_o  (head_ent)
    );

    always_comb begin
        a_valid_o = head_valid & ~head_ent.route;
        c_valid_o = head_valid &  head_ent.route;
        pop       = (a_valid_o & a_ready_i) | (c_valid_o & c_ready_i);
        a_bits_o  = head_ent.bits;
        c_bits_o.opcode  = head_ent.bits.opcode;
        c_bits_o.param   = head_ent.bits.param;
        c_bits_o.size    = head_ent.bits.size;
        c_bits_o.source  = head_ent.bits.source;
        c_bits_o.address = head_ent.bits.address;
        c_bits_o.data    = head_ent.bits.data;
        c_bits_o.corrupt = head_ent.bits.corrupt;
    end

    assign err_o = err_q;

endmodule

// File: tb/tb_tl_a_split_c.sv
// Randomized bench for tl_a_split_c: a message-level generator feeds the merged
// stream and a queue model predicts occupancy, routing, payload and the error flag.
module tb_tl_a_split_c;
    import tl_pkg::*;

    logic  clk_i = 1'b0;
    logic  rst_i;
    logic  in_valid_i;
    logic  in_ready_o;
    logic  in_is_c_i;
    tl_a_t in_bits_i;
    logic  a_valid_o;
    logic  a_ready_i;
    tl_a_t a_bits_o;
    logic  c_valid_o;
    logic  c_ready_i;
    tl_c_t c_bits_o;
    logic  err_o;

    always #5 clk_i = ~clk_i;

    tl_a_split_c dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .in_is_c_i  (in_is_c_i),
        .in_bits_i  (in_bits_i),
        .a_valid_o  (a_valid_o),
        .a_ready_i  (a_ready_i),
        .a_bits_o   (a_bits_o),
        .c_valid_o  (c_valid_o),
        .c_ready_i  (c_ready_i),
        .c_bits_o   (c_bits_o),
        .err_o      (err_o)
    );

    typedef struct packed {
        logic  route;
        tl_a_t bits;
    } exp_t;

    int   n_cmp = 0;
    int   n_bad = 0;

    // reference state
    exp_t q[$];
    int   m_left  = 0;
    logic m_route = 1'b0;
    logic m_err   = 1'b0;

    // message generator state
    int   g_left = 0, g_total = 0;
    logic g_is_c = 1'b0;
    logic [2:0] g_op  = 3'd0;
    logic [3:0] g_size = 4'd0;
    int   mid_rsts = 0;
    int   n_a_out = 0, n_c_out = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_beats(input logic [3:0] size);
        int nbytes = 1 << size;
        return (nbytes <= 8) ? 1 : nbytes / 8;
    endfunction

    function automatic logic ref_has_data(input logic is_c, input logic [2:0] op);
        if (is_c) return (op == 3'd1) || (op == 3'd5) || (op == 3'd7);
        return op <= 3'd3;
    endfunction

    task automatic check_outputs();
        tl_c_t ec;
        chk("in_ready", 128'(in_ready_o), 128'(q.size() < 2));
        chk("a_valid", 128'(a_valid_o), 128'(q.size() > 0 && !q[0].route));
        chk("c_valid", 128'(c_valid_o), 128'(q.size() > 0 &&  q[0].route));
        chk("err", 128'(err_o), 128'(m_err));
        if (q.size() > 0) begin
            if (!q[0].route) begin
                chk("a_bits", 128'(a_bits_o), 128'(q[0].bits));
            end else begin
                ec.opcode  = q[0].bits.opcode;
                ec.param   = q[0].bits.param;
                ec.size    = q[0].bits.size;
                ec.source  = q[0].bits.source;
                ec.address = q[0].bits.address;
                ec.data    = q[0].bits.data;
                ec.corrupt = q[0].bits.corrupt;
                chk("c_bits", 128'(c_bits_o), 128'(ec));
            end
        end
    endtask

    // Advance the model across the coming clock edge.
    task automatic model_step();
        logic do_pop, do_push;
        exp_t e;
        if (rst_i) begin
            q.delete();
            m_left = 0;
            m_err  = 1'b0;
            g_left = 0;
            return;
        end
        do_pop  = (q.size() > 0) && (q[0].route ? c_ready_i : a_ready_i);
        do_push = in_valid_i && (q.size() < 2);
        if (do_pop) begin
            if (q[0].route) n_c_out++; else n_a_out++;
            void'(q.pop_front());
        end
        if (do_push) begin
            e.bits = in_bits_i;
            if (m_left > 0) begin
                if (in_is_c_i != m_route) m_err = 1'b1;
                e.route = m_route;
                m_left--;
            end else begin
                e.route = in_is_c_i;
                if (ref_has_data(in_is_c_i, in_bits_i.opcode) && ref_beats(in_bits_i.size) > 1) begin
                    m_left  = ref_beats(in_bits_i.size) - 1;
                    m_route = in_is_c_i;
                end
            end
            q.push_back(e);
            if (g_left > 0) g_left--;
        end
    endtask

    task automatic drive(input int cyc);
        logic flip;
        if (g_left == 0) begin
            g_is_c  = 1'($urandom_range(0, 1));
            g_op    = 3'($urandom_range(0, 7));
            g_size  = ($urandom_range(0, 9) == 0) ? 4'd7 : 4'($urandom_range(0, 6));
            g_total = ref_beats(g_size);
            if (!ref_has_data(g_is_c, g_op)) g_total = 1;
            g_left  = g_total;
        end
        flip = (g_left < g_total) && ($urandom_range(0, 11) == 0);
        in_valid_i        = ($urandom_range(0, 3) != 0);
        in_is_c_i         = g_is_c ^ flip;
        in_bits_i.opcode  = g_op;
        in_bits_i.param   = 3'($urandom);
        in_bits_i.size    = g_size;
        in_bits_i.source  = 8'($urandom);
        in_bits_i.address = $urandom;
        in_bits_i.data    = {$urandom, $urandom};
        in_bits_i.mask    = 8'($urandom);
        in_bits_i.corrupt = 1'($urandom);
        // Stall windows fill the FIFO so the full/hold path gets exercised.
        if ((cyc % 64) < 8) begin
            a_ready_i = 1'b0;
            c_ready_i = 1'b0;
        end else begin
            a_ready_i = ($urandom_range(0, 3) != 0);
            c_ready_i = ($urandom_range(0, 3) != 0);
        end
        rst_i = ($urandom_range(0, 299) == 0);
        if (g_total == 8 && g_left == 6 && mid_rsts < 4) begin
            rst_i = 1'b1;
            mid_rsts++;
        end
    endtask

    initial begin
        rst_i      = 1'b1;
        in_valid_i = 1'b0;
        in_is_c_i  = 1'b0;
        in_bits_i  = '0;
        a_ready_i  = 1'b1;
        c_ready_i  = 1'b1;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        chk("rst_in_ready", 128'(in_ready_o), 128'(1));
        chk("rst_a_valid", 128'(a_valid_o), 128'(0));
        chk("rst_c_valid", 128'(c_valid_o), 128'(0));
        chk("rst_err", 128'(err_o), 128'(0));

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge clk_i);
            #1;
            drive(cyc);
            @(negedge clk_i);
            check_outputs();
            model_step();
        end

        @(posedge clk_i);
        #1;
        rst_i      = 1'b0;
        in_valid_i = 1'b0;
        a_ready_i  = 1'b1;
        c_ready_i  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            check_outputs();
            model_step();
            @(posedge clk_i);
            #1;
        end
        chk("drained", 128'(q.size()), 128'(0));
        chk("saw_a_beats", 128'(n_a_out > 100), 128'(1));
        chk("saw_c_beats", 128'(n_c_out > 100), 128'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
